// File: rtl/toy_bus_mem_slv_bridge_if.sv
// ToyBus request/ack port plus single-port SRAM port of the memory slave bridge.
// The slave modport is the bridge's view; the master modport is the network/SRAM side.
interface toy_bus_mem_slv_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int MEM_AW = 27
);
  localparam int STRB_W = DATA_W / 8;

  logic              req_vld;
  logic              req_rdy;
  logic [ADDR_W-1:0] req_addr;
  logic [STRB_W-1:0] req_strb;
  logic [DATA_W-1:0] req_data;
  logic              req_opcode;
  logic [ID_W-1:0]   req_src_id;
  logic [ID_W-1:0]   req_tgt_id;

  logic              ack_vld;
  logic              ack_rdy;
  logic              ack_opcode;
  logic [DATA_W-1:0] ack_data;
  logic [ID_W-1:0]   ack_src_id;
  logic [ID_W-1:0]   ack_tgt_id;

  logic              mem_en;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic [DATA_W-1:0] mem_wr_data;
  logic [STRB_W-1:0] mem_wr_byte_en;
  logic              mem_wr_en;

  modport slave (
    input  req_vld, req_addr, req_strb, req_data, req_opcode, req_src_id, req_tgt_id,
    output req_rdy,
    output ack_vld, ack_opcode, ack_data, ack_src_id, ack_tgt_id,
    input  ack_rdy,
    output mem_en, mem_addr, mem_wr_data, mem_wr_byte_en, mem_wr_en,
    input  mem_rd_data
  );

  modport master (
    output req_vld, req_addr, req_strb, req_data, req_opcode, req_src_id, req_tgt_id,
    input  req_rdy,
    input  ack_vld, ack_opcode, ack_data, ack_src_id, ack_tgt_id,
    output ack_rdy,
    input  mem_en, mem_addr, mem_wr_data, mem_wr_byte_en, mem_wr_en,
    output mem_rd_data
  );
endinterface

// File: rtl/toy_bus_mem_slv_bridge.sv
// ToyBus request to synchronous SRAM slave bridge with configurable read latency,
// credit-gated in-order ack FIFO and optional write acks.
module toy_bus_mem_slv_bridge #(
  parameter int              ADDR_W    = 32,
  parameter int              DATA_W    = 32,
  parameter int              ID_W      = 4,
  parameter int              MEM_AW    = 27,
  parameter int              RD_LAT    = 1,
  parameter int              ACK_DEPTH = 4,
  parameter bit              WR_ACK    = 1'b0,
  parameter logic [ID_W-1:0] NODE_ID   = '0
) (
  input logic clk,
  input logic rst_n,
  toy_bus_mem_slv_bridge_if.slave bus
);
  localparam int CNT_W = $clog2(ACK_DEPTH + 1);
  localparam int PTR_W = (ACK_DEPTH > 1) ? $clog2(ACK_DEPTH) : 1;
  localparam int ENT_W = 1 + DATA_W + ID_W;

  // Handshakes: a transfer happens on a cycle where valid && ready; a raised
  // valid keeps its payload stable until that cycle, and ready never looks at valid.
  logic             accept;
  logic             ackreq;
  logic             ack_fire;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [RD_LAT-1:0] pv_q;
  logic [RD_LAT-1:0] pop_q;
  logic [ID_W-1:0]   pid_q [RD_LAT];

  logic [ENT_W-1:0] fifo_q [ACK_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic             fifo_empty;
  logic             push, pop;

  logic              out_vld;
  logic [DATA_W-1:0] out_data;
  logic [ENT_W-1:0]  out_ent;
  logic [ENT_W-1:0]  ack_ent;
  logic              unused_bits;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(ACK_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign bus.req_rdy = (cnt_q < CNT_W'(ACK_DEPTH));
  assign accept      = bus.req_vld && bus.req_rdy;
  assign ackreq      = accept && (!bus.req_opcode || WR_ACK);

  assign bus.mem_en         = accept;
  assign bus.mem_addr       = bus.req_addr[MEM_AW+1:2];
  assign bus.mem_wr_data    = bus.req_data;
  assign bus.mem_wr_byte_en = bus.req_strb;
  assign bus.mem_wr_en      = bus.req_opcode;

  assign unused_bits = ^{bus.req_tgt_id, bus.req_addr};

  // SRAM data is only meaningful in the cycle the matching meta stage leaves the pipe.
  assign out_vld  = pv_q[RD_LAT-1];
  assign out_data = pop_q[RD_LAT-1] ? '0 : bus.mem_rd_data;
  assign out_ent  = {pop_q[RD_LAT-1], out_data, pid_q[RD_LAT-1]};

  assign fifo_empty = (fcnt_q == '0);

  always_comb begin
    bus.ack_vld = 1'b0;
    ack_ent     = '0;
    if (!fifo_empty) begin
      bus.ack_vld = 1'b1;
      ack_ent     = fifo_q[rd_ptr_q];
    end else if (out_vld) begin
      bus.ack_vld = 1'b1;
      ack_ent     = out_ent;
    end
  end

  assign {bus.ack_opcode, bus.ack_data, bus.ack_tgt_id} = ack_ent;
  assign bus.ack_src_id = NODE_ID;

  assign ack_fire = bus.ack_vld && bus.ack_rdy;
  // The credit bound keeps fcnt_q <= ACK_DEPTH, so push never hits a full FIFO.
  assign push     = out_vld && (!fifo_empty || !bus.ack_rdy);
  assign pop      = !fifo_empty && bus.ack_rdy;

  always_comb begin
    cnt_d = cnt_q;
    if (ackreq && !ack_fire)      cnt_d = cnt_q + 1'b1;
    else if (!ackreq && ack_fire) cnt_d = cnt_q - 1'b1;
  end

  always_comb begin
    fcnt_d = fcnt_q;
    if (push && !pop)      fcnt_d = fcnt_q + 1'b1;
    else if (pop && !push) fcnt_d = fcnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      pv_q     <= '0;
      pop_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      for (int i = 0; i < RD_LAT; i++) pid_q[i] <= '0;
      for (int i = 0; i < ACK_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      cnt_q    <= cnt_d;
      fcnt_q   <= fcnt_d;
      pv_q[0]  <= ackreq;
      pop_q[0] <= bus.req_opcode;
      pid_q[0] <= bus.req_src_id;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i]  <= pv_q[i-1];
        pop_q[i] <= pop_q[i-1];
        pid_q[i] <= pid_q[i-1];
      end
      if (push) begin
        fifo_q[wr_ptr_q] <= out_ent;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end
endmodule
